// File: rtl/ex_pkg.sv
// Shared encodings for the execute unit: ALU op codes, RV32M multiply funct3 subset
// and the forwarding match helper used by operand select.
package ex_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    localparam logic [1:0] MUL_F3_MUL    = 2'b00;
    localparam logic [1:0] MUL_F3_MULH   = 2'b01;
    localparam logic [1:0] MUL_F3_MULHSU = 2'b10;
    localparam logic [1:0] MUL_F3_MULHU  = 2'b11;

    // x0 is never forwarded: its architectural value is always zero.
    function automatic logic fwd_hit(
        input logic                  fwd_valid,
        input logic [REG_ADDR_W-1:0] fwd_rd,
        input logic [REG_ADDR_W-1:0] rs
    );
        return fwd_valid && (fwd_rd == rs) && (rs != 5'd0);
    endfunction

endpackage

// File: rtl/ex_mul_pipe.sv
// Pipelined RV32M multiplier: stage 0 holds the operands and feeds the multiply,
// the following stages delay the selected XLEN-bit result until the tail.
module ex_mul_pipe
    import ex_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ROB_IDX_W   = 4,
    parameter int MUL_LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  stall,
    input  logic                  issue_valid,
    input  logic [4:0]            issue_rd,
    input  logic [ROB_IDX_W-1:0]  issue_rob_idx,
    input  logic [1:0]            issue_op,
    input  logic [XLEN-1:0]       issue_operand1,
    input  logic [XLEN-1:0]       issue_operand2,
    output logic                  tail_valid,
    output logic [4:0]            tail_rd,
    output logic [ROB_IDX_W-1:0]  tail_rob_idx,
    output logic [XLEN-1:0]       tail_result,
    output logic                  busy
);

    localparam int NUM_STAGES = MUL_LATENCY - 1;
    localparam int LAST       = NUM_STAGES - 1;

    typedef struct packed {
        logic                  valid;
        logic [4:0]            rd;
        logic [ROB_IDX_W-1:0]  rob_idx;
        logic [1:0]            op;
        logic [XLEN-1:0]       operand1;
        logic [XLEN-1:0]       operand2;
    } mul_stage_t;

    mul_stage_t          stage_r [NUM_STAGES];
    mul_stage_t          carry_s;
    logic                a_sign_s;
    logic                b_sign_s;
    logic [2*XLEN-1:0]   a_wide_s;
    logic [2*XLEN-1:0]   b_wide_s;
    logic [2*XLEN-1:0]   product_s;
    logic [XLEN-1:0]     mul_result_s;

    // Sign-extend per funct3 so one 2*XLEN multiply covers all four variants.
    always_comb begin
        a_sign_s = 1'b0;
        b_sign_s = 1'b0;
        case (stage_r[0].op)
            MUL_F3_MUL: begin
                a_sign_s = 1'b0;
                b_sign_s = 1'b0;
            end
            MUL_F3_MULH: begin
                a_sign_s = stage_r[0].operand1[XLEN-1];
                b_sign_s = stage_r[0].operand2[XLEN-1];
            end
            MUL_F3_MULHSU: begin
                a_sign_s = stage_r[0].operand1[XLEN-1];
                b_sign_s = 1'b0;
            end
            MUL_F3_MULHU: begin
                a_sign_s = 1'b0;
                b_sign_s = 1'b0;
            end
            default: begin
                a_sign_s = 1'b0;
                b_sign_s = 1'b0;
            end
        endcase
        a_wide_s  = {{XLEN{a_sign_s}}, stage_r[0].operand1};
        b_wide_s  = {{XLEN{b_sign_s}}, stage_r[0].operand2};
        product_s = a_wide_s * b_wide_s;
        if (stage_r[0].op == MUL_F3_MUL) begin
            mul_result_s = product_s[XLEN-1:0];
        end else begin
            mul_result_s = product_s[2*XLEN-1:XLEN];
        end
    end

    // Payload handed from stage 0 to stage 1: the result rides in operand1.
    always_comb begin
        carry_s          = '0;
        carry_s.valid    = stage_r[0].valid;
        carry_s.rd       = stage_r[0].rd;
        carry_s.rob_idx  = stage_r[0].rob_idx;
        carry_s.op       = stage_r[0].op;
        carry_s.operand1 = mul_result_s;
        carry_s.operand2 = {XLEN{1'b0}};
    end

    // Stage registers: reset clears everything, flush kills valids, stall holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                stage_r[k] <= '0;
            end
        end else if (flush) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                stage_r[k].valid <= 1'b0;
            end
        end else if (!stall) begin
            stage_r[0].valid    <= issue_valid;
            stage_r[0].rd       <= issue_rd;
            stage_r[0].rob_idx  <= issue_rob_idx;
            stage_r[0].op       <= issue_op;
            stage_r[0].operand1 <= issue_operand1;
            stage_r[0].operand2 <= issue_operand2;
            for (int k = 1; k < NUM_STAGES; k++) begin
                if (k == 1) begin
                    stage_r[k] <= carry_s;
                end else begin
                    stage_r[k] <= stage_r[k-1];
                end
            end
        end
    end

    // Any valid stage means the multiplier still owes a completion.
    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            busy = busy | stage_r[k].valid;
        end
    end

    assign tail_valid   = stage_r[LAST].valid;
    assign tail_rd      = stage_r[LAST].rd;
    assign tail_rob_idx = stage_r[LAST].rob_idx;
    assign tail_result  = (NUM_STAGES == 1) ? mul_result_s : stage_r[LAST].operand1;

endmodule

// File: rtl/ex_multicycle_unit.sv
// Execute unit: forwarded operand select, single-cycle ALU, pipelined multiplier
// and one registered completion port tagged with the ROB index.
module ex_multicycle_unit
    import ex_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ROB_IDX_W   = 4,
    parameter int NUM_FWD     = 2,
    parameter int MUL_LATENCY = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     out_ready,
    input  logic                     in_is_mul,
    input  logic [3:0]               in_op,
    input  logic                     in_use_imm,
    input  logic [4:0]               in_rs1,
    input  logic [4:0]               in_rs2,
    input  logic [XLEN-1:0]          in_data_rs1,
    input  logic [XLEN-1:0]          in_data_rs2,
    input  logic [XLEN-1:0]          in_immediate,
    input  logic [4:0]               in_rd,
    input  logic [ROB_IDX_W-1:0]     in_rob_idx,
    input  logic [NUM_FWD-1:0]       in_fwd_valid,
    input  logic [5*NUM_FWD-1:0]     in_fwd_rd,
    input  logic [XLEN*NUM_FWD-1:0]  in_fwd_data,
    input  logic                     in_flush,
    input  logic                     in_downstream_ready,
    output logic                     out_complete,
    output logic [ROB_IDX_W-1:0]     out_complete_idx,
    output logic [4:0]               out_rd,
    output logic [XLEN-1:0]          out_result,
    output logic                     out_mul_busy
);

    logic [XLEN-1:0]       rs1_val_s;
    logic [XLEN-1:0]       rs2_val_s;
    logic [XLEN-1:0]       operand2_s;
    logic [XLEN-1:0]       alu_result_s;
    logic                  stall_s;
    logic                  accept_s;
    logic                  mul_issue_s;
    logic                  alu_issue_s;
    logic                  mul_tail_valid_s;
    logic [4:0]            mul_tail_rd_s;
    logic [ROB_IDX_W-1:0]  mul_tail_rob_idx_s;
    logic [XLEN-1:0]       mul_tail_result_s;

    // Walk ports from highest index down so the lowest matching index wins.
    always_comb begin
        rs1_val_s = in_data_rs1;
        rs2_val_s = in_data_rs2;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            rs1_val_s = fwd_hit(in_fwd_valid[i], in_fwd_rd[i*5 +: 5], in_rs1) ?
                        in_fwd_data[i*XLEN +: XLEN] : rs1_val_s;
            rs2_val_s = fwd_hit(in_fwd_valid[i], in_fwd_rd[i*5 +: 5], in_rs2) ?
                        in_fwd_data[i*XLEN +: XLEN] : rs2_val_s;
        end
        operand2_s = in_use_imm ? in_immediate : rs2_val_s;
    end

    // Single-cycle ALU; shift amounts come from operand2[4:0].
    always_comb begin
        alu_result_s = {XLEN{1'b0}};
        case (alu_op_e'(in_op))
            ALU_ADD:  alu_result_s = rs1_val_s + operand2_s;
            ALU_SUB:  alu_result_s = rs1_val_s - operand2_s;
            ALU_SLL:  alu_result_s = rs1_val_s << operand2_s[4:0];
            ALU_SLT:  alu_result_s = {{(XLEN-1){1'b0}}, ($signed(rs1_val_s) < $signed(operand2_s))};
            ALU_SLTU: alu_result_s = {{(XLEN-1){1'b0}}, (rs1_val_s < operand2_s)};
            ALU_XOR:  alu_result_s = rs1_val_s ^ operand2_s;
            ALU_SRL:  alu_result_s = rs1_val_s >> operand2_s[4:0];
            ALU_SRA:  alu_result_s = $unsigned($signed(rs1_val_s) >>> operand2_s[4:0]);
            ALU_OR:   alu_result_s = rs1_val_s | operand2_s;
            ALU_AND:  alu_result_s = rs1_val_s & operand2_s;
            default:  alu_result_s = {XLEN{1'b0}};
        endcase
    end

    // An ALU op would land on the output register in the same edge as the MUL tail.
    assign stall_s     = out_complete && !in_downstream_ready;
    assign out_ready   = !reset && !in_flush && !stall_s && !(!in_is_mul && mul_tail_valid_s);
    assign accept_s    = in_valid && out_ready;
    assign mul_issue_s = accept_s && in_is_mul;
    assign alu_issue_s = accept_s && !in_is_mul;

    ex_mul_pipe #(
        .XLEN        (XLEN),
        .ROB_IDX_W   (ROB_IDX_W),
        .MUL_LATENCY (MUL_LATENCY)
    ) u_mul_pipe (
        .clk            (clk),
        .reset          (reset),
        .flush          (in_flush),
        .stall          (stall_s),
        .issue_valid    (mul_issue_s),
        .issue_rd       (in_rd),
        .issue_rob_idx  (in_rob_idx),
        .issue_op       (in_op[1:0]),
        .issue_operand1 (rs1_val_s),
        .issue_operand2 (operand2_s),
        .tail_valid     (mul_tail_valid_s),
        .tail_rd        (mul_tail_rd_s),
        .tail_rob_idx   (mul_tail_rob_idx_s),
        .tail_result    (mul_tail_result_s),
        .busy           (out_mul_busy)
    );

    // Completion register: MUL tail first, then an ALU op accepted this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_complete     <= 1'b0;
            out_complete_idx <= {ROB_IDX_W{1'b0}};
            out_rd           <= 5'd0;
            out_result       <= {XLEN{1'b0}};
        end else if (in_flush) begin
            out_complete <= 1'b0;
        end else if (!stall_s) begin
            if (mul_tail_valid_s) begin
                out_complete     <= 1'b1;
                out_complete_idx <= mul_tail_rob_idx_s;
                out_rd           <= mul_tail_rd_s;
                out_result       <= mul_tail_result_s;
            end else if (alu_issue_s) begin
                out_complete     <= 1'b1;
                out_complete_idx <= in_rob_idx;
                out_rd           <= in_rd;
                out_result       <= alu_result_s;
            end else begin
                out_complete <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ex_multicycle_unit.sv
// Directed self-checking bench for ex_multicycle_unit with hand-computed expectations.
module tb_ex_multicycle_unit;
    import ex_pkg::*;

    localparam int XLEN        = 32;
    localparam int ROB_IDX_W   = 4;
    localparam int NUM_FWD     = 2;
    localparam int MUL_LATENCY = 3;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid;
    logic                    out_ready;
    logic                    in_is_mul;
    logic [3:0]              in_op;
    logic                    in_use_imm;
    logic [4:0]              in_rs1;
    logic [4:0]              in_rs2;
    logic [XLEN-1:0]         in_data_rs1;
    logic [XLEN-1:0]         in_data_rs2;
    logic [XLEN-1:0]         in_immediate;
    logic [4:0]              in_rd;
    logic [ROB_IDX_W-1:0]    in_rob_idx;
    logic [NUM_FWD-1:0]      in_fwd_valid;
    logic [5*NUM_FWD-1:0]    in_fwd_rd;
    logic [XLEN*NUM_FWD-1:0] in_fwd_data;
    logic                    in_flush;
    logic                    in_downstream_ready;
    logic                    out_complete;
    logic [ROB_IDX_W-1:0]    out_complete_idx;
    logic [4:0]              out_rd;
    logic [XLEN-1:0]         out_result;
    logic                    out_mul_busy;

    int   n_checks;
    int   n_errors;
    vec_t alu_vecs [9];
    vec_t mul_vecs [8];

    ex_multicycle_unit #(
        .XLEN(XLEN), .ROB_IDX_W(ROB_IDX_W), .NUM_FWD(NUM_FWD), .MUL_LATENCY(MUL_LATENCY)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .out_ready(out_ready),
        .in_is_mul(in_is_mul), .in_op(in_op), .in_use_imm(in_use_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_data_rs1(in_data_rs1), .in_data_rs2(in_data_rs2),
        .in_immediate(in_immediate), .in_rd(in_rd), .in_rob_idx(in_rob_idx),
        .in_fwd_valid(in_fwd_valid), .in_fwd_rd(in_fwd_rd), .in_fwd_data(in_fwd_data),
        .in_flush(in_flush), .in_downstream_ready(in_downstream_ready),
        .out_complete(out_complete), .out_complete_idx(out_complete_idx), .out_rd(out_rd),
        .out_result(out_result), .out_mul_busy(out_mul_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_completion(input string tag, input logic [31:0] res,
                                    input logic [4:0] rd, input logic [3:0] rob);
        check_eq({tag, "_valid"}, 32'(out_complete), 32'd1);
        check_eq({tag, "_result"}, out_result, res);
        check_eq({tag, "_rd"}, 32'(out_rd), 32'(rd));
        check_eq({tag, "_rob"}, 32'(out_complete_idx), 32'(rob));
    endtask

    task automatic drive_idle();
        in_valid = 1'b0; in_is_mul = 1'b0; in_op = 4'd0; in_use_imm = 1'b0;
        in_rs1 = 5'd1; in_rs2 = 5'd2; in_data_rs1 = 32'd0; in_data_rs2 = 32'd0;
        in_immediate = 32'd0; in_rd = 5'd0; in_rob_idx = 4'd0;
        in_fwd_valid = 2'b00; in_fwd_rd = 10'd0; in_fwd_data = 64'd0; in_flush = 1'b0;
    endtask

    task automatic drive_op(input logic is_mul, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] rd, input logic [3:0] rob);
        drive_idle();
        in_valid = 1'b1; in_is_mul = is_mul; in_op = op;
        in_data_rs1 = a; in_data_rs2 = b; in_rd = rd; in_rob_idx = rob;
    endtask

    task automatic fwd_case(input string tag, input logic [4:0] rs1, input logic [31:0] d1,
                            input logic [4:0] rs2, input logic [31:0] d2, input logic [1:0] fv,
                            input logic [9:0] frd, input logic [63:0] fdata,
                            input logic use_imm, input logic [31:0] imm, input logic [31:0] exp);
        drive_op(1'b0, ALU_ADD, d1, d2, 5'd20, 4'd4);
        in_rs1 = rs1; in_rs2 = rs2; in_fwd_valid = fv; in_fwd_rd = frd;
        in_fwd_data = fdata; in_use_imm = use_imm; in_immediate = imm;
        tick();
        check_eq(tag, out_result, exp);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        alu_vecs[0] = '{ALU_SUB,  32'h00000005, 32'h00000007, 32'hFFFFFFFE};
        alu_vecs[1] = '{ALU_SLL,  32'h00000001, 32'h00000021, 32'h00000002};
        alu_vecs[2] = '{ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001};
        alu_vecs[3] = '{ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        alu_vecs[4] = '{ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0};
        alu_vecs[5] = '{ALU_SRL,  32'h80000000, 32'h00000004, 32'h08000000};
        alu_vecs[6] = '{ALU_SRA,  32'h80000000, 32'h00000004, 32'hF8000000};
        alu_vecs[7] = '{ALU_OR,   32'h0000F000, 32'h0000000F, 32'h0000F00F};
        alu_vecs[8] = '{ALU_AND,  32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00};
        mul_vecs[0] = '{{2'b00, MUL_F3_MULH},   32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
        mul_vecs[1] = '{{2'b00, MUL_F3_MULHU},  32'hFFFFFFFF, 32'h00000002, 32'h00000001};
        mul_vecs[2] = '{{2'b00, MUL_F3_MUL},    32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE};
        mul_vecs[3] = '{{2'b00, MUL_F3_MULH},   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
        mul_vecs[4] = '{{2'b00, MUL_F3_MULHSU}, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        mul_vecs[5] = '{{2'b00, MUL_F3_MULHU},  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        mul_vecs[6] = '{{2'b00, MUL_F3_MULHSU}, 32'h80000000, 32'h00000003, 32'hFFFFFFFE};
        mul_vecs[7] = '{{2'b00, MUL_F3_MUL},    32'h00012345, 32'h00001000, 32'h12345000};

        drive_idle();
        in_downstream_ready = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        check_eq("rst_complete", 32'(out_complete), 32'd0);
        check_eq("rst_idx", 32'(out_complete_idx), 32'd0);
        check_eq("rst_rd", 32'(out_rd), 32'd0);
        check_eq("rst_result", out_result, 32'd0);
        check_eq("rst_busy", 32'(out_mul_busy), 32'd0);
        check_eq("rst_ready", 32'(out_ready), 32'd0);
        reset = 1'b0;

        // ADD 5 + 7 completes on the next edge
        drive_op(1'b0, ALU_ADD, 32'd5, 32'd7, 5'd3, 4'd2);
        #1 check_eq("add_ready", 32'(out_ready), 32'd1);
        tick();
        drive_idle();
        check_completion("add", 32'd12, 5'd3, 4'd2);

        for (int k = 0; k < 9; k++) begin
            drive_op(1'b0, alu_vecs[k].op, alu_vecs[k].a, alu_vecs[k].b, 5'(k + 1), 4'(k));
            tick();
            check_completion("alu", alu_vecs[k].exp, 5'(k + 1), 4'(k));
        end
        drive_idle();
        tick();
        check_eq("alu_drain", 32'(out_complete), 32'd0);

        // back-to-back MULs: vector c-2 completes after the edge ending cycle c
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                drive_op(1'b1, mul_vecs[c].op, mul_vecs[c].a, mul_vecs[c].b, 5'(c + 8), 4'(c + 1));
                #1 check_eq("mul_ready", 32'(out_ready), 32'd1);
            end else begin
                drive_idle();
            end
            tick();
            if (c >= 2) begin
                check_completion("mul", mul_vecs[c-2].exp, 5'(c + 6), 4'(c - 1));
            end else begin
                check_eq("mul_latency", 32'(out_complete), 32'd0);
                check_eq("mul_busy", 32'(out_mul_busy), 32'd1);
            end
        end
        drive_idle();
        tick();
        check_eq("mul_drain", 32'(out_complete), 32'd0);
        check_eq("mul_idle", 32'(out_mul_busy), 32'd0);

        // structural hazard: ALU two cycles behind a MUL waits one cycle
        drive_op(1'b1, {2'b00, MUL_F3_MUL}, 32'd3, 32'd4, 5'd10, 4'd9);
        tick();
        drive_idle();
        #1 check_eq("haz_ready_c1", 32'(out_ready), 32'd1);
        tick();
        drive_op(1'b0, ALU_ADD, 32'd1, 32'd1, 5'd11, 4'd10);
        #1 check_eq("haz_ready_c2", 32'(out_ready), 32'd0);
        in_is_mul = 1'b1;
        #1 check_eq("haz_mul_unblocked", 32'(out_ready), 32'd1);
        in_is_mul = 1'b0;
        tick();
        check_completion("haz_mul", 32'd12, 5'd10, 4'd9);
        check_eq("haz_ready_c3", 32'(out_ready), 32'd1);
        tick();
        drive_idle();
        check_completion("haz_alu", 32'd2, 5'd11, 4'd10);
        tick();
        check_eq("haz_drain", 32'(out_complete), 32'd0);

        fwd_case("fwd_prio",     5'd5, 32'h100, 5'd0, 32'h0,   2'b11, {5'd5, 5'd5},
                 {32'hB, 32'hA},  1'b0, 32'd0, 32'h0000000A);
        fwd_case("fwd_port1",    5'd5, 32'h100, 5'd0, 32'h0,   2'b10, {5'd5, 5'd5},
                 {32'hB, 32'hA},  1'b0, 32'd0, 32'h0000000B);
        fwd_case("fwd_x0",       5'd0, 32'h100, 5'd0, 32'h0,   2'b11, {5'd0, 5'd0},
                 {32'hB, 32'hA},  1'b0, 32'd0, 32'h00000100);
        fwd_case("fwd_rs2",      5'd1, 32'h1,   5'd6, 32'h300, 2'b11, {5'd6, 5'd7},
                 {32'h20, 32'h40}, 1'b0, 32'd0, 32'h00000021);
        fwd_case("fwd_imm",      5'd1, 32'h1,   5'd6, 32'h300, 2'b11, {5'd6, 5'd7},
                 {32'h20, 32'h40}, 1'b1, 32'd7, 32'h00000008);
        fwd_case("fwd_both",     5'd5, 32'h0,   5'd5, 32'h0,   2'b01, {5'd0, 5'd5},
                 {32'h0, 32'h3},  1'b0, 32'd0, 32'h00000006);
        drive_idle();
        tick();

        // downstream back-pressure freezes output and multiplier stages
        in_downstream_ready = 1'b0;
        drive_op(1'b1, {2'b00, MUL_F3_MUL}, 32'd6, 32'd7, 5'd13, 4'd5);
        tick();
        drive_op(1'b1, {2'b00, MUL_F3_MUL}, 32'd3, 32'd5, 5'd14, 4'd6);
        tick();
        drive_idle();
        tick();
        check_eq("stall_ready", 32'(out_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            check_completion("stall_hold", 32'd42, 5'd13, 4'd5);
            check_eq("stall_busy", 32'(out_mul_busy), 32'd1);
            if (i < 4) tick();
        end
        in_downstream_ready = 1'b1;
        tick();
        check_completion("stall_next", 32'd15, 5'd14, 4'd6);
        tick();
        check_eq("stall_no_dup", 32'(out_complete), 32'd0);
        check_eq("stall_idle", 32'(out_mul_busy), 32'd0);

        // flush with MUL in stage 1 and an ALU op presented
        drive_op(1'b1, {2'b00, MUL_F3_MUL}, 32'd2, 32'd9, 5'd15, 4'd7);
        tick();
        drive_idle();
        tick();
        drive_op(1'b0, ALU_ADD, 32'd4, 32'd4, 5'd16, 4'd8);
        in_flush = 1'b1;
        #1 check_eq("flush_ready", 32'(out_ready), 32'd0);
        tick();
        drive_idle();
        check_eq("flush_complete", 32'(out_complete), 32'd0);
        check_eq("flush_busy", 32'(out_mul_busy), 32'd0);
        tick();
        check_eq("flush_no_late", 32'(out_complete), 32'd0);

        // reset in the middle of a multiply discards it
        drive_op(1'b1, {2'b00, MUL_F3_MUL}, 32'd2, 32'd3, 5'd17, 4'd9);
        tick();
        drive_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("rstmid_busy", 32'(out_mul_busy), 32'd0);
        check_eq("rstmid_complete", 32'(out_complete), 32'd0);
        tick();
        tick();
        check_eq("rstmid_no_late", 32'(out_complete), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ex_multicycle_unit.md
Name: ex_multicycle_unit

Overview:
- Parametrised next-generation execute unit for the ROB-based pipeline.
- Accepts one issued op per cycle through a valid/ready handshake and resolves operands through NUM_FWD generic forwarding ports.
- Executes single-cycle ALU ops and a MUL_LATENCY-deep pipelined multiplier (RV32M MUL/MULH/MULHSU/MULHU).
- Retires results in order of completion on a single completion port, tagged with the ROB index; supports global flush.

Parameters:
- XLEN, 32, datapath width.
- ROB_IDX_W, 4, ROB index width.
- NUM_FWD, 2, number of forwarding sources; index 0 has highest priority.
- MUL_LATENCY, 3, issue-to-complete cycles for MUL ops (legal range 2..8).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous active-high reset.
- in_valid  in  1  issue slot holds an op.
- out_ready  out  1  unit accepts the op this cycle.
- in_is_mul  in  1  op targets the multiplier.
- in_op  in  4  ALU op code (ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND) or, in bits [1:0], the MUL funct3 subset.
- in_use_imm  in  1  operand2 = in_immediate.
- in_rs1, in_rs2  in  5 each  source register numbers.
- in_data_rs1, in_data_rs2  in  XLEN each  register-file values.
- in_immediate  in  XLEN  immediate operand.
- in_rd  in  5  destination register.
- in_rob_idx  in  ROB_IDX_W  ROB tag.
- in_fwd_valid  in  NUM_FWD  forwarding source is valid and writes.
- in_fwd_rd  in  5*NUM_FWD  forwarding destination registers, packed.
- in_fwd_data  in  XLEN*NUM_FWD  forwarding values, packed.
- in_flush  in  1  kill all in-flight work.
- in_downstream_ready  in  1  consumer takes the completion this cycle.
- out_complete  out  1  completion valid.
- out_complete_idx  out  ROB_IDX_W  ROB tag of the completing op.
- out_rd  out  5  destination register of the completing op.
- out_result  out  XLEN  result of the completing op.
- out_mul_busy  out  1  any multiplier stage is valid.

Behaviour:
- Operand select (combinational, per operand): the lowest index i with in_fwd_valid[i], in_fwd_rd[i]==rs, and rs!=0 supplies the value; otherwise in_data_rs*. in_use_imm overrides operand2 after forwarding.
- stall = out_complete && !in_downstream_ready. While stalled, the output register and every multiplier stage hold.
- Structural hazard: an ALU op issued at cycle t would collide with a MUL issued at t-(MUL_LATENCY-1).
- out_ready = !reset && !in_flush && !stall && !(!in_is_mul && mul_stage[MUL_LATENCY-2].valid). MUL ops are never blocked by this hazard. out_ready may depend on in_is_mul.
- Accept = in_valid && out_ready.
- ALU latency is 1: the result is in the output register on the next edge.
- MUL latency is MUL_LATENCY: the op enters stage 0 on accept, advances one stage per non-stalled cycle, and the last stage loads the output register.
- Result widths:
  - MUL returns the low XLEN bits.
  - MULH/MULHSU/MULHU return the high XLEN bits of the 2*XLEN product, signed×signed, signed×unsigned and unsigned×unsigned respectively.
  - Shifts use operand2[4:0].
  - SLT/SLTU return zero-extended 0/1.
- Output register loads when !stall, from exactly one source: the MUL tail if valid, else an accepted ALU op, else it clears out_complete.
- Flush: on the in_flush edge all stage valids and out_complete clear. An op presented in the flush cycle is not accepted. Flush beats stall.
- Reset (synchronous): out_complete=0, out_complete_idx=0, out_rd=0, out_result=0, all stage valids=0, out_mul_busy=0. Reset asserted mid-multiply discards the op with no completion.
- The x0 destination is carried normally; the ROB discards it.

Decomposition:
- Shared package ex_pkg:
  - ALU op enum (4-bit).
  - MUL funct3 constants.
  - Stage payload struct {valid, rd, rob_idx, op, operand1, operand2}.
- One sub-module, ex_mul_pipe (parametrised MUL_LATENCY, XLEN).
  - Computes the product in stage 0; the remaining stages are delay registers carrying the payload.
  - Takes a stall input and a flush input.

Test Plan:
- Reset for 2 cycles, then issue ADD of 5 and 7 with rd=3, rob=2 → next cycle out_complete=1, out_result=12, out_rd=3, out_complete_idx=2.
- MULH with 0xFFFFFFFF×0x00000002 (signed) → exactly 3 cycles later out_result=0xFFFFFFFF. MULHU with the same operands → 0x00000001.
- Issue MUL at cycle 0, then an ALU op at cycle 2 → out_ready=0 at cycle 2 and the ALU op is accepted at cycle 3. Completion order is MUL at cycle 3, ALU at cycle 4.
- Both forwarding ports match rs1=5, port0 data=0xA and port1 data=0xB → port0 value used. With rs1=0 matching a port, in_data_rs1 is used.
- Hold in_downstream_ready=0 for 4 cycles with a MUL in flight → out_complete, out_result and stage contents frozen; no op is lost or duplicated after release.
- Assert in_flush while MUL stage 1 is valid and an ALU op is presented → no completion for either op; out_mul_busy=0 next cycle.
